// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI mode controller.
//   mode_t      : 2-bit video mode index
//   timing_t    : the eight 12-bit timing words consumed by the sync generator
//   MODE_TABLE  : timing words for each supported mode, indexed by mode_t
//   state_t     : controller FSM encoding (ST_RUN, ST_WAIT, ST_LOAD, ST_HOLD)
package hdmi_pkg;

    typedef logic [1:0] mode_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
    } timing_t;

    // Order per entry: h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end
    localparam timing_t MODE_TABLE [0:3] = '{
        '{12'd799,  12'd95,  12'd143, 12'd783,  12'd524, 12'd1, 12'd34, 12'd514}, // 640x480
        '{12'd1055, 12'd127, 12'd215, 12'd1015, 12'd627, 12'd3, 12'd26, 12'd626}, // 800x600
        '{12'd1649, 12'd39,  12'd259, 12'd1539, 12'd749, 12'd4, 12'd24, 12'd744}, // 1280x720
        '{12'd1343, 12'd135, 12'd295, 12'd1319, 12'd805, 12'd5, 12'd34, 12'd802}  // 1024x768
    };

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic timing_t mode_timing(input mode_t mode);
        return MODE_TABLE[mode];
    endfunction

endpackage

// File: rtl/hdmi_mode_ctrl_if.sv
// Signal bundle between the mode controller and its surroundings (control
// registers / buttons on one side, hdmi_generator and pixel PLL on the other).
//   master modport : system/generator side; drives requests, frame_start, pll_locked
//   slave modport  : hdmi_mode_ctrl; drives timing words, generator reset, status
// Signals:
//   mode_req, mode_sel        request strobe and requested mode
//   frame_start, pll_locked   generator frame pulse, asynchronous PLL lock
//   h_*/v_* timing words      12-bit timing set for the generator
//   gen_reset_n               active-low generator reset
//   clk_sel, cur_mode         pixel-clock mux select, mode on screen
//   busy, done, timeout_err   status
interface hdmi_mode_ctrl_if;
    import hdmi_pkg::*;

    logic        mode_req;
    mode_t       mode_sel;
    logic        frame_start;
    logic        pll_locked;

    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_start;
    logic [11:0] h_end;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_start;
    logic [11:0] v_end;

    logic        gen_reset_n;
    mode_t       clk_sel;
    mode_t       cur_mode;
    logic        busy;
    logic        done;
    logic        timeout_err;

    modport master (
        output mode_req, mode_sel, frame_start, pll_locked,
        input  h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end,
        input  gen_reset_n, clk_sel, cur_mode, busy, done, timeout_err
    );

    modport slave (
        input  mode_req, mode_sel, frame_start, pll_locked,
        output h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end,
        output gen_reset_n, clk_sel, cur_mode, busy, done, timeout_err
    );

endinterface

// File: rtl/hdmi_sync2.sv
// Two-flop synchroniser for a single asynchronous level (pll_locked).
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset; both flops clear to 0
//   d        in  asynchronous input
//   q        out synchronised output, two cycles of latency
module hdmi_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_mode_ctrl.sv
// HDMI video mode controller. Owns the eight timing words driving the sync
// generator and performs glitch-free mode switches: wait for a frame boundary
// (or a timeout), hold the generator in reset, load the new timing set and
// pixel-clock select, wait for PLL lock, then release the generator.
// Ports:
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   bus       slave side of hdmi_mode_ctrl_if (requests, generator handshake,
//             timing words, status)
// Parameters:
//   DEFAULT_MODE  mode loaded out of reset
//   HOLD_CYCLES   minimum HOLD-state cycles with the generator in reset (>= 2)
//   TIMEOUT       WAIT cycles before a switch is forced without frame_start
module hdmi_mode_ctrl
    import hdmi_pkg::*;
#(
    parameter mode_t       DEFAULT_MODE = 2'd0,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned TIMEOUT      = 2000000
) (
    input  logic            clk,
    input  logic            reset_n,
    hdmi_mode_ctrl_if.slave bus
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic              pll_locked_s;

    state_t            state;
    timing_t           timing;
    mode_t             target;
    mode_t             cur_mode;
    mode_t             clk_sel;
    mode_t             pend_mode;
    logic              pend_valid;
    logic              gen_reset_n;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              req_any;
    mode_t             req_mode;

    hdmi_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.pll_locked),
        .q       (pll_locked_s)
    );

    // A request parked while busy is serviced on the first RUN cycle as if it
    // had just arrived; a fresh strobe in that same cycle is newer and wins.
    always_comb begin
        req_any  = bus.mode_req | pend_valid;
        req_mode = bus.mode_req ? bus.mode_sel : pend_mode;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_HOLD;
            timing      <= mode_timing(DEFAULT_MODE);
            target      <= DEFAULT_MODE;
            cur_mode    <= DEFAULT_MODE;
            clk_sel     <= DEFAULT_MODE;
            pend_mode   <= DEFAULT_MODE;
            pend_valid  <= 1'b0;
            gen_reset_n <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            done <= 1'b0;

            // Any new request clears the sticky flag; a timeout set below in
            // the same cycle overrides this.
            if (bus.mode_req) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    pend_valid <= 1'b0;
                    if (req_any) begin
                        if (req_mode != cur_mode) begin
                            target   <= req_mode;
                            wait_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= ST_WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    // frame_start has priority over the timeout
                    if (bus.frame_start) begin
                        gen_reset_n <= 1'b0;
                        state       <= ST_LOAD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        gen_reset_n <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_LOAD: begin
                    timing   <= mode_timing(target);
                    clk_sel  <= target;
                    cur_mode <= target;
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (hold_cnt >= HOLD_LAST && pll_locked_s) begin
                        gen_reset_n <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_RUN;
                    end else if (hold_cnt < HOLD_LAST) begin
                        // Saturate so an indefinitely missing lock cannot wrap
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_HOLD;
                end
            endcase

            // One-deep pending slot, last request wins
            if (state != ST_RUN && bus.mode_req) begin
                pend_valid <= 1'b1;
                pend_mode  <= bus.mode_sel;
            end
        end
    end

    assign bus.h_total     = timing.h_total;
    assign bus.h_sync      = timing.h_sync;
    assign bus.h_start     = timing.h_start;
    assign bus.h_end       = timing.h_end;
    assign bus.v_total     = timing.v_total;
    assign bus.v_sync      = timing.v_sync;
    assign bus.v_start     = timing.v_start;
    assign bus.v_end       = timing.v_end;
    assign bus.gen_reset_n = gen_reset_n;
    assign bus.clk_sel     = clk_sel;
    assign bus.cur_mode    = cur_mode;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Directed bench for hdmi_mode_ctrl. Instance A (long timeout) covers reset,
// frame-aligned switches, same-mode requests, PLL-lock wait, pending requests
// and mid-switch reset. Instance B (TIMEOUT=50) covers the timeout path.
// Each request pushes the expected post-completion state onto a per-instance
// queue; a monitor pops and compares on every done pulse.
module tb_hdmi_mode_ctrl;

    localparam int HOLD = 16;

    localparam int TAB [4][8] = '{
        '{799,  95,  143, 783,  524, 1, 34, 514},
        '{1055, 127, 215, 1015, 627, 3, 26, 626},
        '{1649, 39,  259, 1539, 749, 4, 24, 744},
        '{1343, 135, 295, 1319, 805, 5, 34, 802}
    };

    typedef struct packed {
        logic [1:0] mode;
        logic       te;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n_a;
    logic reset_n_b;

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb_a [$];
    exp_t sb_b [$];

    hdmi_mode_ctrl_if bus_a ();
    hdmi_mode_ctrl_if bus_b ();

    hdmi_mode_ctrl #(
        .DEFAULT_MODE (2'd0),
        .HOLD_CYCLES  (HOLD),
        .TIMEOUT      (1000)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n_a),
        .bus     (bus_a.slave)
    );

    hdmi_mode_ctrl #(
        .DEFAULT_MODE (2'd0),
        .HOLD_CYCLES  (HOLD),
        .TIMEOUT      (50)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n_b),
        .bus     (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] exp_timing(input logic [1:0] m);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[83:0], 12'(TAB[m][i])};
        return r;
    endfunction

    // {busy, gen_reset_n, timeout_err, clk_sel, cur_mode, timing}
    function automatic logic [127:0] exp_snap(input logic [1:0] m, input logic te);
        return {25'd0, 1'b0, 1'b1, te, m, m, exp_timing(m)};
    endfunction

    function automatic logic [127:0] reset_snap();
        return {25'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, exp_timing(2'd0)};
    endfunction

    function automatic logic [127:0] snap_a();
        return {25'd0, bus_a.busy, bus_a.gen_reset_n, bus_a.timeout_err, bus_a.clk_sel,
                bus_a.cur_mode, bus_a.h_total, bus_a.h_sync, bus_a.h_start, bus_a.h_end,
                bus_a.v_total, bus_a.v_sync, bus_a.v_start, bus_a.v_end};
    endfunction

    function automatic logic [127:0] snap_b();
        return {25'd0, bus_b.busy, bus_b.gen_reset_n, bus_b.timeout_err, bus_b.clk_sel,
                bus_b.cur_mode, bus_b.h_total, bus_b.h_sync, bus_b.h_start, bus_b.h_end,
                bus_b.v_total, bus_b.v_sync, bus_b.v_start, bus_b.v_end};
    endfunction

    task automatic push_a(input logic [1:0] m, input logic te);
        exp_t e;
        e.mode = m;
        e.te   = te;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] m, input logic te);
        exp_t e;
        e.mode = m;
        e.te   = te;
        sb_b.push_back(e);
    endtask

    // Bounded wait for gen_reset_n to reach a level; n = cycles waited
    task automatic wait_gen_a(input logic level, output int n);
        n = 0;
        while (bus_a.gen_reset_n !== level && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_gen_b(input logic level, output int n);
        n = 0;
        while (bus_b.gen_reset_n !== level && n < 500) begin
            tick();
            n++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus_a.done === 1'b1) begin
            check("a_done_expected", 128'(sb_a.size() != 0), 128'd1);
            if (sb_a.size() != 0) begin
                exp_t e;
                e = sb_a.pop_front();
                check("a_done_state", snap_a(), exp_snap(e.mode, e.te));
            end
        end
        if (bus_b.done === 1'b1) begin
            check("b_done_expected", 128'(sb_b.size() != 0), 128'd1);
            if (sb_b.size() != 0) begin
                exp_t e;
                e = sb_b.pop_front();
                check("b_done_state", snap_b(), exp_snap(e.mode, e.te));
            end
        end
    end

    initial begin
        int n;
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        bus_a.mode_req = 1'b0; bus_a.mode_sel = 2'd0; bus_a.frame_start = 1'b0;
        bus_a.pll_locked = 1'b1;
        bus_b.mode_req = 1'b0; bus_b.mode_sel = 2'd0; bus_b.frame_start = 1'b0;
        bus_b.pll_locked = 1'b1;
        repeat (3) tick();

        // Reset values
        check("a_reset_state", snap_a(), reset_snap());
        check("a_reset_done", 128'(bus_a.done), 128'd0);
        check("b_reset_state", snap_b(), reset_snap());
        push_a(2'd0, 1'b0);
        push_b(2'd0, 1'b0);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;

        // 1: generator held for exactly HOLD cycles after reset release
        wait_gen_a(1'b1, n);
        check("t1_hold_len", 128'(n), 128'(HOLD));
        check("t1_done", 128'(bus_a.done), 128'd1);
        tick();
        tick();

        // 2: frame-aligned switch to mode 2
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd2; push_a(2'd2, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        check("t2_busy", 128'(bus_a.busy), 128'd1);
        check("t2_gen_in_wait", 128'(bus_a.gen_reset_n), 128'd1);
        repeat (99) tick();
        bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        check("t2_gen_low_latency", 128'(bus_a.gen_reset_n), 128'd0);
        check("t2_old_timing_in_load", 128'(bus_a.h_total), 128'd799);
        wait_gen_a(1'b1, n);
        check("t2_low_len", 128'(n), 128'(HOLD + 1));
        check("t2_h_total", 128'(bus_a.h_total), 128'd1649);
        check("t2_v_end", 128'(bus_a.v_end), 128'd744);
        check("t2_clk_sel", 128'(bus_a.clk_sel), 128'd2);
        tick();

        // 3: same-mode request completes at once
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd2; push_a(2'd2, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        check("t3_done", 128'(bus_a.done), 128'd1);
        check("t3_busy", 128'(bus_a.busy), 128'd0);
        check("t3_gen", 128'(bus_a.gen_reset_n), 128'd1);
        tick();
        check("t3_done_one_cycle", 128'(bus_a.done), 128'd0);

        // 4: timeout forces the switch after 50 WAIT cycles
        bus_b.mode_req = 1'b1; bus_b.mode_sel = 2'd1; push_b(2'd1, 1'b1);
        tick();
        bus_b.mode_req = 1'b0;
        wait_gen_b(1'b0, n);
        check("t4_wait_len", 128'(n), 128'd50);
        check("t4_timeout_err", 128'(bus_b.timeout_err), 128'd1);
        wait_gen_b(1'b1, n);
        check("t4_released", 128'(bus_b.gen_reset_n), 128'd1);
        tick();
        bus_b.mode_req = 1'b1; bus_b.mode_sel = 2'd1; push_b(2'd1, 1'b0);
        tick();
        bus_b.mode_req = 1'b0;
        check("t4_err_cleared", 128'(bus_b.timeout_err), 128'd0);
        // frame_start on the last WAIT cycle beats the timeout
        bus_b.mode_req = 1'b1; bus_b.mode_sel = 2'd2; push_b(2'd2, 1'b0);
        tick();
        bus_b.mode_req = 1'b0;
        repeat (49) tick();
        bus_b.frame_start = 1'b1;
        tick();
        bus_b.frame_start = 1'b0;
        check("t4_tie_gen_low", 128'(bus_b.gen_reset_n), 128'd0);
        check("t4_tie_no_err", 128'(bus_b.timeout_err), 128'd0);
        wait_gen_b(1'b1, n);
        tick();

        // 5: lock wait plus two requests parked while busy
        bus_a.pll_locked = 1'b0;
        repeat (3) tick();
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd0; push_a(2'd0, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd1;
        tick();
        bus_a.mode_sel = 2'd3; push_a(2'd3, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        repeat (196) tick();
        check("t5_hold_no_lock", 128'(bus_a.gen_reset_n), 128'd0);
        check("t5_busy_no_lock", 128'(bus_a.busy), 128'd1);
        bus_a.pll_locked = 1'b1;
        wait_gen_a(1'b1, n);
        check("t5_lock_to_release", 128'(n), 128'd3);
        tick();
        check("t5_pending_busy", 128'(bus_a.busy), 128'd1);
        check("t5_pending_gen", 128'(bus_a.gen_reset_n), 128'd1);
        repeat (10) tick();
        bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        wait_gen_a(1'b1, n);
        check("t5_pending_len", 128'(n), 128'(HOLD + 1));
        check("t5_cur_mode", 128'(bus_a.cur_mode), 128'd3);
        repeat (3) tick();
        check("t5_no_extra_switch", 128'(bus_a.busy), 128'd0);

        // 6a: reset during WAIT
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd1; push_a(2'd1, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        repeat (5) tick();
        reset_n_a = 1'b0;
        #1;
        check("t6_wait_reset_state", snap_a(), reset_snap());
        check("t6_wait_reset_done", 128'(bus_a.done), 128'd0);
        sb_a.delete();
        tick();
        push_a(2'd0, 1'b0);
        reset_n_a = 1'b1;
        wait_gen_a(1'b1, n);
        check("t6_wait_rehold", 128'(n), 128'(HOLD));
        repeat (5) tick();
        check("t6_wait_idle", 128'(bus_a.busy), 128'd0);

        // 6b: reset during HOLD with a request pending
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd2; push_a(2'd2, 1'b0);
        tick();
        bus_a.mode_req = 1'b0;
        bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        tick();
        tick();
        bus_a.mode_req = 1'b1; bus_a.mode_sel = 2'd3;
        tick();
        bus_a.mode_req = 1'b0;
        tick();
        reset_n_a = 1'b0;
        #1;
        check("t6_hold_reset_state", snap_a(), reset_snap());
        sb_a.delete();
        tick();
        push_a(2'd0, 1'b0);
        reset_n_a = 1'b1;
        wait_gen_a(1'b1, n);
        check("t6_hold_rehold", 128'(n), 128'(HOLD));
        repeat (5) tick();
        check("t6_hold_no_pending", 128'(bus_a.busy), 128'd0);
        check("t6_hold_mode", 128'(bus_a.cur_mode), 128'd0);

        check("a_sb_drained", 128'(sb_a.size()), 128'd0);
        check("b_sb_drained", 128'(sb_b.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
